// File: rtl/hilo_md_pkg.sv
// ============================================================================
// Module      : hilo_md_pkg
// Description : Shared definitions for the HI/LO multiply/divide controller.
//               Holds the E-stage op encoding, the two-state FSM encoding,
//               the default busy-window latencies and the counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_md_pkg;

    // E-stage multiply/divide op encoding. Code 7 is reserved and treated as NONE.
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Latency counter width; comfortably covers any realistic window length.
    localparam int CNT_W = 16;

endpackage : hilo_md_pkg

`default_nettype wire

// File: rtl/md_busy_cnt.sv
// ============================================================================
// Module      : md_busy_cnt
// Description : Loadable down-counter timing the multiply/divide busy window.
//               Counts down to zero and stops; done is high while count == 1,
//               i.e. during the last busy cycle.
// Ports       : clk      - clock
//               reset    - asynchronous active-low reset (count -> 0)
//               load     - load load_val this cycle
//               load_val - window length in cycles
//               done     - count == 1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_cnt
    import hilo_md_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == W'(1));

endmodule : md_busy_cnt

`default_nettype wire

// File: rtl/hilo_md_ctrl.sv
// ============================================================================
// Module      : hilo_md_ctrl
// Description : HI/LO register pair and multiply/divide sequencing for the
//               five-stage pipeline. Computes the result at issue, holds it
//               in hi_tmp/lo_tmp for a fixed busy window, then commits it.
//               Raises stall_md for D-stage HI/LO instructions while busy.
// Ports       : clk, reset (async active-low)
//               E_mdOp/E_valid/E_rsData/E_rtData - E-stage op and operands
//               E_hiloSel  - 0 read HI, 1 read LO onto E_hiloData
//               D_isMd     - D-stage instruction touches HI/LO
//               E_hiloData - combinational HI/LO read
//               hi, lo     - architectural registers
//               busy       - window active; stall_md - hold F/D, bubble E
// Config      : MDU_DIVZERO_HOLD_EN - when defined, divide by zero keeps
//               HI/LO unchanged with a 1-cycle window; otherwise it runs the
//               full divide window and writes HI=dividend, LO=all ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_md_ctrl
    import hilo_md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_mdOp,
    input  logic        E_valid,
    input  logic [31:0] E_rsData,
    input  logic [31:0] E_rtData,
    input  logic        E_hiloSel,
    input  logic        D_isMd,
    output logic [31:0] E_hiloData,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    md_state_t          state_q;
    md_state_t          state_d;
    logic               start;
    logic               done;
    logic               mt_hi;
    logic               mt_lo;
    logic [31:0]        hi_tmp;
    logic [31:0]        lo_tmp;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic [CNT_W-1:0]   res_lat;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;

    wire is_idle = (state_q == ST_IDLE);

    assign start = E_valid && is_idle &&
                   (E_mdOp == OP_MULT || E_mdOp == OP_MULTU ||
                    E_mdOp == OP_DIV  || E_mdOp == OP_DIVU);
    assign mt_hi = E_valid && is_idle && (E_mdOp == OP_MTHI);
    assign mt_lo = E_valid && is_idle && (E_mdOp == OP_MTLO);

    // Operands sign-extended to 64 bits so the product is the exact signed result.
    assign prod_s = $signed({{32{E_rsData[31]}}, E_rsData}) *
                    $signed({{32{E_rtData[31]}}, E_rtData});
    assign prod_u = {32'd0, E_rsData} * {32'd0, E_rtData};
    // Signed / and % truncate toward zero; remainder follows the dividend sign.
    assign quo_s  = $signed(E_rsData) / $signed(E_rtData);
    assign rem_s  = $signed(E_rsData) % $signed(E_rtData);

    always_comb begin
        res_hi  = '0;
        res_lo  = '0;
        res_lat = CNT_W'(MULT_CYCLES);
        case (E_mdOp)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                res_lat = CNT_W'(DIV_CYCLES);
                if (E_rtData == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
                    // Commit the current values back: HI/LO are effectively untouched.
                    res_hi  = hi;
                    res_lo  = lo;
                    res_lat = CNT_W'(1);
`else
                    res_hi  = E_rsData;
                    res_lo  = 32'hFFFF_FFFF;
`endif
                end else if (E_mdOp == OP_DIV) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end else begin
                    res_hi = E_rsData % E_rtData;
                    res_lo = E_rsData / E_rtData;
                end
            end
            default: ;
        endcase
    end

    md_busy_cnt #(
        .W (CNT_W)
    ) u_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (res_lat),
        .done     (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
        end else begin
            if (start) begin
                hi_tmp <= res_hi;
                lo_tmp <= res_lo;
            end
            if (!is_idle && done) begin
                hi <= hi_tmp;
                lo <= lo_tmp;
            end else if (mt_hi) begin
                hi <= E_rsData;
            end else if (mt_lo) begin
                lo <= E_rsData;
            end
        end
    end

    assign busy       = (state_q == ST_BUSY);
    assign stall_md   = D_isMd && (busy || start);
    assign E_hiloData = E_hiloSel ? lo : hi;

endmodule : hilo_md_ctrl

`default_nettype wire

// File: tb/tb_hilo_md_ctrl.sv
// ============================================================================
// Module      : tb_hilo_md_ctrl
// Description : Self-checking bench for hilo_md_ctrl. A table of
//               multiply/divide vectors is issued back to back, followed by
//               hand-written MTHI/MTLO, divide-by-zero and mid-op reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_md_ctrl;
    import hilo_md_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  E_mdOp;
    logic        E_valid;
    logic [31:0] E_rsData;
    logic [31:0] E_rtData;
    logic        E_hiloSel;
    logic        D_isMd;
    logic [31:0] E_hiloData;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    int n_checks = 0;
    int n_fails  = 0;

    hilo_md_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .E_mdOp     (E_mdOp),
        .E_valid    (E_valid),
        .E_rsData   (E_rsData),
        .E_rtData   (E_rtData),
        .E_hiloSel  (E_hiloSel),
        .D_isMd     (D_isMd),
        .E_hiloData (E_hiloData),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall_md   (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge: issues the op in this cycle, checks the busy
    // window cycle by cycle, and returns at the falling edge of the first
    // idle cycle after commit, with results checked.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        chk({nm, "_idle_at_issue"}, 32'(busy), 32'd0);
        E_valid  = 1'b1;
        E_mdOp   = op;
        E_rsData = rs;
        E_rtData = rt;
        #1;
        chk({nm, "_stall_start"}, 32'(stall_md), 32'd1);
        @(negedge clk);
        E_valid = 1'b0;
        E_mdOp  = OP_NONE;
        for (int i = 0; i < lat; i++) begin
            #1;
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            chk({nm, "_stall_busy"}, 32'(stall_md), 32'd1);
            @(negedge clk);
        end
        #1;
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
        chk({nm, "_stall_end"}, 32'(stall_md), 32'd0);
        chk({nm, "_hi"}, hi, exp_hi);
        chk({nm, "_lo"}, lo, exp_lo);
        E_hiloSel = 1'b0;
        #1;
        chk({nm, "_rd_hi"}, E_hiloData, exp_hi);
        E_hiloSel = 1'b1;
        #1;
        chk({nm, "_rd_lo"}, E_hiloData, exp_lo);
        E_hiloSel = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"mult_neg1x2",   OP_MULT,  32'hFFFF_FFFF, 32'd2,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{"multu_big_x2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,          5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"mult_2p16sq",   OP_MULT,  32'h0001_0000, 32'h0001_0000,  5,  32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{"div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE,  10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{"divu_7_2",      OP_DIVU,  32'd7,         32'd2,          10, 32'h0000_0001, 32'h0000_0003};

        reset     = 1'b0;
        E_mdOp    = OP_NONE;
        E_valid   = 1'b0;
        E_rsData  = '0;
        E_rtData  = '0;
        E_hiloSel = 1'b0;
        D_isMd    = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_md), 32'd0);
        chk("rst_hi",    hi, 32'd0);
        chk("rst_lo",    lo, 32'd0);
        chk("rst_rd",    E_hiloData, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back issue: each op starts in the first cycle after the previous commit.
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].name, vecs[v].op, vecs[v].rs, vecs[v].rt,
                   vecs[v].lat, vecs[v].exp_hi, vecs[v].exp_lo);
        end

        // MTHI then MTLO in consecutive cycles; each readable the next cycle.
        @(negedge clk);
        E_valid  = 1'b1;
        E_mdOp   = OP_MTHI;
        E_rsData = 32'h1234_5678;
        #1;
        chk("mthi_stall", 32'(stall_md), 32'd0);
        @(negedge clk);
        E_mdOp   = OP_MTLO;
        E_rsData = 32'h9ABC_DEF0;
        E_hiloSel = 1'b0;
        #1;
        chk("mthi_rd",   E_hiloData, 32'h1234_5678);
        chk("mthi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        E_valid  = 1'b0;
        E_mdOp   = OP_NONE;
        E_hiloSel = 1'b1;
        #1;
        chk("mtlo_rd",   E_hiloData, 32'h9ABC_DEF0);
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk("mt_hi_kept", hi, 32'h1234_5678);
        E_hiloSel = 1'b0;

        // Divide by zero with HI = LO = 0x55 preloaded.
        @(negedge clk);
        E_valid  = 1'b1;
        E_mdOp   = OP_MTHI;
        E_rsData = 32'h55;
        @(negedge clk);
        E_mdOp   = OP_MTLO;
        @(negedge clk);
        E_valid  = 1'b0;
        E_mdOp   = OP_NONE;
        #1;
        chk("dz_pre_hi", hi, 32'h55);
        chk("dz_pre_lo", lo, 32'h55);
`ifdef MDU_DIVZERO_HOLD_EN
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1, 32'h55, 32'h55);
`else
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 10, 32'h0000_1234, 32'hFFFF_FFFF);
`endif

        // Reset asserted in busy cycle 4 of a divide aborts and clears everything.
        @(negedge clk);
        E_valid  = 1'b1;
        E_mdOp   = OP_DIV;
        E_rsData = 32'd100;
        E_rtData = 32'd7;
        @(negedge clk);
        E_valid  = 1'b0;
        E_mdOp   = OP_NONE;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_stall", 32'(stall_md), 32'd0);
        chk("abort_hi",    hi, 32'd0);
        chk("abort_lo",    lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("mult_after_rst", OP_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_hilo_md_ctrl

`default_nettype wire
